nibble_uart_tx: RTL and testbench
=================================

Name: nibble_uart_tx

Overview:
- Downstream consumer of the CPU output port: captures each 4-bit value the CPU emits on its out pins (qualified by the data-valid strobe).
- Buffers captured values in a small FIFO.
- Transmits each value to the host as one ASCII hex character over UART 8N1.
- Counterpart to the programmer's UART RX path; uses the same baud parameters.

Parameters:
- BAUD_COUNTS_PER_BIT, 521, clock cycles per UART bit (10 MHz clk).
- BAUD_RATE_COUNTER_BITWIDTH, 10, width of the baud counter; must satisfy 2^width > BAUD_COUNTS_PER_BIT.
- UART_DATA_LENGTH, 8, data bits per frame.
- FIFO_DEPTH, 4, number of buffered nibbles; power of two.
- FIFO_ADDR_WIDTH, 2, log2(FIFO_DEPTH).

Ports:
- clk_i  in  1  system clock, single clock domain
- reset_i  in  1  synchronous, active-high reset
- data_i  in  4  CPU output nibble
- data_valid_strb_i  in  1  CPU data-valid strobe; may stay high for several cycles
- tx_o  out  1  UART serial output, idle high
- busy_o  out  1  high while a frame is in progress (any state other than IDLE)
- fifo_full_o  out  1  FIFO holds FIFO_DEPTH entries
- fifo_level_o  out  FIFO_ADDR_WIDTH+1  current FIFO occupancy
- overflow_o  out  1  sticky; a nibble was dropped because the FIFO was full

Behaviour:
- Reset state: tx_o=1, busy_o=0, fifo_full_o=0, fifo_level_o=0, overflow_o=0, FSM=IDLE, baud counter=0, FIFO pointers=0, strobe history register=0.
- Reset mid-frame: the frame is aborted, tx_o is 1 from the cycle after reset is sampled, and FIFO contents are discarded.
- Push detect:
  - A push occurs on the rising edge of the strobe: strobe=1 this cycle and strobe=0 in the previous cycle.
  - data_i is sampled in that same cycle.
  - A strobe held high pushes exactly once.
- Push acceptance:
  - Accepted if level < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the nibble is dropped, level is unchanged, and overflow_o is set and stays 1 until reset.
- Simultaneous push and pop: the level is unchanged and both operations take effect.
- Pop: only from IDLE when level > 0. A push into an empty FIFO cannot be popped in the same cycle.
- ASCII mapping: 0–9 -> 0x30–0x39; 10–15 -> 0x41–0x46 (uppercase A–F).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_o=1. If level > 0, then at the clock edge: pop the head, load the shift register with its ASCII code, clear the baud counter, and go to START.
  - START: tx_o=0 for BAUD_COUNTS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx_o = shift register bit, LSB first. Each bit lasts BAUD_COUNTS_PER_BIT cycles. After UART_DATA_LENGTH bits, go to STOP.
  - STOP: tx_o=1 for BAUD_COUNTS_PER_BIT cycles, then go to IDLE.
- Baud counter: counts 0..BAUD_COUNTS_PER_BIT-1; wraps to 0 at each bit boundary.
- tx_o is registered; there are no glitches.
- Latency: a push into an empty FIFO while the FSM is IDLE gives a start-bit falling edge on tx_o 2 cycles after the strobe rising edge (1 cycle push, 1 cycle pop/load).
- Frame length: exactly 10*BAUD_COUNTS_PER_BIT cycles of non-idle line time.
- Back-to-back frames are separated by exactly 1 IDLE cycle with tx_o=1.
- busy_o: 0 only in IDLE.
- fifo_full_o and fifo_level_o are registered and reflect occupancy after the current edge.
- Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH. Full/empty are derived from the level counter, not from pointer compare.

Test Plan (bench uses BAUD_COUNTS_PER_BIT=4):
1. Reset, then strobe a single-cycle pulse with data_i=0xA:
   - tx_o falls 2 cycles later.
   - Decoded frame is 0x41 ('A'), bits 1,0,0,0,0,0,1,0 LSB first, each 4 cycles; stop bit high.
   - busy_o is high for 40 cycles.
2. Hold the strobe high for 20 cycles with data_i=0x3: exactly one frame (0x33) is sent and fifo_level_o peaks at 1.
3. Issue 5 distinct pulses (0x0, 0x1, 0x2, 0x3, 0xF), 2 cycles apart, while IDLE:
   - The first nibble is popped immediately and 4 are buffered, so none is dropped and overflow_o stays 0.
   - A 6th pulse sent while full sets overflow_o and is dropped.
   - Output sequence: 0x30, 0x31, 0x32, 0x33, 0x46, with 1 idle cycle between frames.
4. With the FIFO full and the FSM in IDLE with a pop pending, assert a push in the pop cycle: the push is accepted, the level stays 4, and overflow_o stays 0.
5. Assert reset_i during DATA bit 3 of a frame with 2 nibbles queued:
   - tx_o=1 the next cycle, level=0, busy_o=0, overflow_o=0.
   - No further frames are sent.
6. Push 9 nibbles with spacing longer than one frame: all 9 are transmitted in order, covering pointer wrap-around, and fifo_level_o never exceeds 1.

Source files
------------

// File: rtl/nibble_uart_tx.sv
// Captures CPU output nibbles on strobe rising edges, buffers them in a small
// FIFO and sends each one to the host as an ASCII hex character (UART 8N1).
module nibble_uart_tx #(
    parameter int unsigned BAUD_COUNTS_PER_BIT        = 521,
    parameter int unsigned BAUD_RATE_COUNTER_BITWIDTH = 10,
    parameter int unsigned UART_DATA_LENGTH           = 8,
    parameter int unsigned FIFO_DEPTH                 = 4,
    parameter int unsigned FIFO_ADDR_WIDTH            = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [3:0]                 data_i,
    input  logic                       data_valid_strb_i,
    output logic                       tx_o,
    output logic                       busy_o,
    output logic                       fifo_full_o,
    output logic [FIFO_ADDR_WIDTH:0]   fifo_level_o,
    output logic                       overflow_o
);

    localparam int unsigned LVL_W = FIFO_ADDR_WIDTH + 1;
    localparam int unsigned CNT_W = BAUD_RATE_COUNTER_BITWIDTH;
    localparam int unsigned BIT_W = (UART_DATA_LENGTH > 1) ? $clog2(UART_DATA_LENGTH) : 1;
    localparam int unsigned PTR_W = FIFO_ADDR_WIDTH;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_COUNTS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_LENGTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Hex digit to ASCII: 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
    function automatic logic [7:0] to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

    logic                        strb_q;
    logic [3:0]                  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]            wr_ptr_q;
    logic [PTR_W-1:0]            rd_ptr_q;
    logic [LVL_W-1:0]            level_q;
    logic [LVL_W-1:0]            level_d;
    logic                        full_q;
    logic                        overflow_q;

    state_t                      state_q;
    state_t                      state_d;
    logic [CNT_W-1:0]            cnt_q;
    logic [CNT_W-1:0]            cnt_d;
    logic [BIT_W-1:0]            bit_q;
    logic [BIT_W-1:0]            bit_d;
    logic [UART_DATA_LENGTH-1:0] shift_q;
    logic [UART_DATA_LENGTH-1:0] shift_d;
    logic                        tx_q;
    logic                        tx_d;
    logic                        busy_q;

    logic                        push_c;
    logic                        pop_c;
    logic                        accept_c;

    // A held strobe only pushes on its first cycle; a pop frees a slot in the same edge
    assign push_c   = data_valid_strb_i & ~strb_q;
    assign pop_c    = (state_q == IDLE) && (level_q != '0);
    assign accept_c = push_c && ((level_q < LVL_FULL) || pop_c);
    assign level_d  = level_q + LVL_W'(accept_c) - LVL_W'(pop_c);

    // FIFO storage (contents need no reset; pointers and level gate reads)
    always_ff @(posedge clk_i) begin
        if (accept_c) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    // Strobe history, FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            strb_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            strb_q  <= data_valid_strb_i;
            level_q <= level_d;
            full_q  <= (level_d == LVL_FULL);
            if (accept_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_c && !accept_c) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Transmit FSM state register; tx and busy are registered from next-state values
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Transmit FSM next-state and line-level logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pop_c) begin
                    state_d = START;
                    shift_d = UART_DATA_LENGTH'(to_ascii(mem[rd_ptr_q]));
                    tx_d    = 1'b0;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (cnt_q == CNT_LAST) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = {1'b0, shift_q[UART_DATA_LENGTH-1:1]};
                        tx_d    = shift_d[0];
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign fifo_full_o  = full_q;
    assign fifo_level_o = level_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_nibble_uart_tx.sv
// Scoreboard bench for nibble_uart_tx: expected ASCII bytes are queued as
// nibbles are strobed in; a line monitor decodes frames and compares them.
module tb_nibble_uart_tx;

    localparam int unsigned BPB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] data = 4'h0;
    logic       strb = 1'b0;
    logic       tx;
    logic       busy;
    logic       full;
    logic [2:0] level;
    logic       overflow;

    int         tests = 0;
    int         fails = 0;
    int         frames = 0;
    bit         mon_en = 1'b1;
    bit         mon_busy = 1'b0;
    logic [7:0] sb[$];
    int         gaps[$];

    nibble_uart_tx #(
        .BAUD_COUNTS_PER_BIT       (BPB),
        .BAUD_RATE_COUNTER_BITWIDTH(3),
        .UART_DATA_LENGTH          (8),
        .FIFO_DEPTH                (4),
        .FIFO_ADDR_WIDTH           (2)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .data_i           (data),
        .data_valid_strb_i(strb),
        .tx_o             (tx),
        .busy_o           (busy),
        .fifo_full_o      (full),
        .fifo_level_o     (level),
        .overflow_o       (overflow)
    );

    always #5 clk = ~clk;

    // Expected character for a nibble
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n <= 4'd9) return 8'd48 + {4'd0, n};
        return 8'd65 + {4'd0, n} - 8'd10;
    endfunction

    // Line monitor: decodes 8N1 frames at negedges and checks them against the scoreboard
    initial begin : monitor
        logic       prev_tx;
        int         idle_cnt;
        logic [7:0] got;
        logic [7:0] exp;
        logic       b;
        bit         shape_ok;
        prev_tx  = 1'b1;
        idle_cnt = 0;
        b        = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && !reset && prev_tx === 1'b1 && tx === 1'b0) begin
                mon_busy = 1'b1;
                gaps.push_back(idle_cnt);
                shape_ok = 1'b1;
                got = 8'h00;
                for (int i = 1; i < BPB; i++) begin
                    @(negedge clk);
                    if (tx !== 1'b0) shape_ok = 1'b0;
                end
                for (int k = 0; k < 8; k++) begin
                    for (int i = 0; i < BPB; i++) begin
                        @(negedge clk);
                        if (i == 0) b = tx;
                        else if (tx !== b) shape_ok = 1'b0;
                    end
                    got[k] = b;
                end
                for (int i = 0; i < BPB; i++) begin
                    @(negedge clk);
                    if (tx !== 1'b1) shape_ok = 1'b0;
                end
                frames++;
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL frame: unexpected frame 0x%02h, expected no frame", got);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp || !shape_ok) begin
                        fails++;
                        $display("FAIL frame: got 0x%02h shape_ok=%0d, expected 0x%02h shape_ok=1",
                                 got, shape_ok, exp);
                    end
                end
                idle_cnt = 0;
                mon_busy = 1'b0;
            end else if (tx === 1'b1) begin
                idle_cnt++;
            end
            prev_tx = tx;
        end
    end

    // Global time limit
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        strb  = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        gaps.delete();
    endtask

    // One-cycle strobe pulse; the nibble is sampled on the edge before return
    task automatic pulse(input logic [3:0] n, input bit expect_frame);
        @(posedge clk); #1;
        data = n;
        strb = 1'b1;
        if (expect_frame) sb.push_back(hex_char(n));
        @(posedge clk); #1;
        strb = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !mon_busy && busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        tests += 5;
        if (tx !== 1'b1)       begin fails++; $display("FAIL reset_tx: got %b, expected 1", tx); end
        if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        if (full !== 1'b0)     begin fails++; $display("FAIL reset_full: got %b, expected 0", full); end
        if (level !== 3'd0)    begin fails++; $display("FAIL reset_level: got %0d, expected 0", level); end
        if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_single();
        int  cnt;
        bit  ok;
        pulse(4'hA, 1'b1);
        tests += 3;
        if (tx !== 1'b1)    begin fails++; $display("FAIL single_tx_e0: got %b, expected 1", tx); end
        if (level !== 3'd1) begin fails++; $display("FAIL single_level: got %0d, expected 1", level); end
        @(posedge clk); #1;
        if (tx !== 1'b0)    begin fails++; $display("FAIL single_latency: got tx=%b, expected 0", tx); end
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy === 1'b1) cnt++;
            else break;
        end
        tests++;
        if (cnt != 10 * BPB) begin fails++; $display("FAIL single_busy_len: got %0d, expected %0d", cnt, 10 * BPB); end
        wait_drain(200, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL single_drain: got timeout, expected drained"); end
    endtask

    task automatic test_held_strobe();
        int max_lvl;
        int f0;
        bit ok;
        apply_reset();
        f0 = frames;
        max_lvl = 0;
        @(posedge clk); #1;
        data = 4'h3;
        strb = 1'b1;
        sb.push_back(hex_char(4'h3));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (int'(level) > max_lvl) max_lvl = int'(level);
        end
        @(posedge clk); #1;
        strb = 1'b0;
        wait_drain(200, ok);
        repeat (60) @(negedge clk);
        tests += 3;
        if (!ok)              begin fails++; $display("FAIL held_drain: got timeout, expected drained"); end
        if (max_lvl != 1)     begin fails++; $display("FAIL held_peak_level: got %0d, expected 1", max_lvl); end
        if (frames - f0 != 1) begin fails++; $display("FAIL held_frames: got %0d, expected 1", frames - f0); end
    endtask

    task automatic test_fifo_fill_overflow();
        logic [3:0] vals [5];
        bit ok;
        vals = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hF};
        apply_reset();
        foreach (vals[i]) pulse(vals[i], 1'b1);
        tests += 3;
        if (level !== 3'd4)    begin fails++; $display("FAIL fill_level: got %0d, expected 4", level); end
        if (full !== 1'b1)     begin fails++; $display("FAIL fill_full: got %b, expected 1", full); end
        if (overflow !== 1'b0) begin fails++; $display("FAIL fill_no_overflow: got %b, expected 0", overflow); end
        pulse(4'h9, 1'b0);
        tests += 2;
        if (overflow !== 1'b1) begin fails++; $display("FAIL overflow_set: got %b, expected 1", overflow); end
        if (level !== 3'd4)    begin fails++; $display("FAIL overflow_level: got %0d, expected 4", level); end
        wait_drain(400, ok);
        tests += 3;
        if (!ok)               begin fails++; $display("FAIL fill_drain: got timeout, expected drained"); end
        if (gaps.size() != 5)  begin fails++; $display("FAIL fill_frame_count: got %0d, expected 5", gaps.size()); end
        if (overflow !== 1'b1) begin fails++; $display("FAIL overflow_sticky: got %b, expected 1", overflow); end
        for (int i = 1; i < gaps.size(); i++) begin
            tests++;
            if (gaps[i] != 1) begin fails++; $display("FAIL b2b_gap%0d: got %0d idle cycles, expected 1", i, gaps[i]); end
        end
    endtask

    task automatic test_push_on_pop();
        logic [3:0] vals [5];
        bit found;
        bit ok;
        vals = '{4'h4, 4'h5, 4'h6, 4'h8, 4'h9};
        apply_reset();
        foreach (vals[i]) pulse(vals[i], 1'b1);
        tests++;
        if (level !== 3'd4) begin fails++; $display("FAIL pop_push_pre_level: got %0d, expected 4", level); end
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin found = 1'b1; break; end
        end
        tests++;
        if (!found) begin fails++; $display("FAIL pop_push_idle: got no idle cycle, expected one"); end
        data = 4'h7;
        strb = 1'b1;
        sb.push_back(hex_char(4'h7));
        @(posedge clk); #1;
        strb = 1'b0;
        tests += 3;
        if (level !== 3'd4)    begin fails++; $display("FAIL pop_push_level: got %0d, expected 4", level); end
        if (overflow !== 1'b0) begin fails++; $display("FAIL pop_push_overflow: got %b, expected 0", overflow); end
        if (full !== 1'b1)     begin fails++; $display("FAIL pop_push_full: got %b, expected 1", full); end
        wait_drain(400, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL pop_push_drain: got timeout, expected drained"); end
    endtask

    task automatic test_reset_mid_frame();
        int lows;
        mon_en = 1'b0;
        apply_reset();
        @(posedge clk); #1;
        data = 4'h1;
        strb = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(posedge clk); #1;
            strb = (k == 1 || k == 3);
            data = 4'(k + 2);
        end
        tests += 2;
        if (level !== 3'd2) begin fails++; $display("FAIL midreset_pre_level: got %0d, expected 2", level); end
        if (busy !== 1'b1)  begin fails++; $display("FAIL midreset_pre_busy: got %b, expected 1", busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        tests += 4;
        if (tx !== 1'b1)       begin fails++; $display("FAIL midreset_tx: got %b, expected 1", tx); end
        if (level !== 3'd0)    begin fails++; $display("FAIL midreset_level: got %0d, expected 0", level); end
        if (busy !== 1'b0)     begin fails++; $display("FAIL midreset_busy: got %b, expected 0", busy); end
        if (overflow !== 1'b0) begin fails++; $display("FAIL midreset_overflow: got %b, expected 0", overflow); end
        reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        tests++;
        if (lows != 0) begin fails++; $display("FAIL midreset_quiet: got %0d active cycles, expected 0", lows); end
        mon_en = 1'b1;
    endtask

    task automatic test_pointer_wrap();
        logic [3:0] vals [9];
        int max_lvl;
        int f0;
        bit ok;
        vals = '{4'h5, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h9};
        apply_reset();
        f0 = frames;
        max_lvl = 0;
        foreach (vals[i]) begin
            pulse(vals[i], 1'b1);
            if (int'(level) > max_lvl) max_lvl = int'(level);
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (int'(level) > max_lvl) max_lvl = int'(level);
            end
        end
        wait_drain(200, ok);
        tests += 3;
        if (!ok)              begin fails++; $display("FAIL wrap_drain: got timeout, expected drained"); end
        if (max_lvl != 1)     begin fails++; $display("FAIL wrap_peak_level: got %0d, expected 1", max_lvl); end
        if (frames - f0 != 9) begin fails++; $display("FAIL wrap_frames: got %0d, expected 9", frames - f0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_held_strobe();
        test_fifo_fill_overflow();
        test_push_on_pop();
        test_reset_mid_frame();
        test_pointer_wrap();
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
